// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: source indices, buffer entry
// layout and the round-robin wrap helper.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_AW   = 5;

    localparam int NSRC    = 3;
    localparam logic [1:0] SRC_LD  = 2'd0;
    localparam logic [1:0] SRC_FPU = 2'd1;
    localparam logic [1:0] SRC_ALU = 2'd2;

    typedef struct packed {
        logic [WB_AW-1:0]   rd;
        logic               fp;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == SRC_ALU) ? SRC_LD : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: searches from (ptr+1) mod 3, and the pointer
// moves to the winner at the edge (reset points at 2 so source 0 wins first).
module rr_arb3
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] req,
    output logic [NSRC-1:0] gnt,
    output logic            gnt_valid,
    output logic [1:0]      gnt_idx
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NSRC; k++) begin
            cand = rr_next(cand);
            if (!gnt_valid && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = gnt_valid ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SRC_ALU;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Writeback stage: one-entry buffer per producer, independent round-robin
// arbiters for the int and fp register files, registered write ports.
module wb_arbiter_stage
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic            ld_fp,
    input  logic [XLEN-1:0] ld_data,
    input  logic            fpu_valid,
    output logic            fpu_ready,
    input  logic [AW-1:0]   fpu_rd,
    input  logic            fpu_fp,
    input  logic [XLEN-1:0] fpu_data,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic            alu_fp,
    input  logic [XLEN-1:0] alu_data,
    output logic            we,
    output logic [AW-1:0]   write_address,
    output logic [XLEN-1:0] data_in,
    output logic            wef,
    output logic [AW-1:0]   write_addressf,
    output logic [XLEN-1:0] data_inf,
    output logic            wb_busy
);

    logic [NSRC-1:0] full_q, full_d;
    wb_entry_t       ent_q [NSRC];
    wb_entry_t       ent_d [NSRC];
    wb_entry_t       src_ent [NSRC];
    logic [NSRC-1:0] src_valid, src_ready, accept;
    logic [NSRC-1:0] int_req, fp_req, int_gnt, fp_gnt, gnt;
    logic            int_gv, fp_gv;
    logic [1:0]      int_idx, fp_idx;
    wb_entry_t       int_ent, fp_ent;

    logic            we_q, we_d, wef_q, wef_d;
    logic [AW-1:0]   waddr_q, waddr_d, waddrf_q, waddrf_d;
    logic [XLEN-1:0] wdata_q, wdata_d, wdataf_q, wdataf_d;

    always_comb begin
        src_valid          = {alu_valid, fpu_valid, ld_valid};
        src_ent[SRC_LD]    = '{rd: ld_rd,  fp: ld_fp,  data: ld_data};
        src_ent[SRC_FPU]   = '{rd: fpu_rd, fp: fpu_fp, data: fpu_data};
        src_ent[SRC_ALU]   = '{rd: alu_rd, fp: alu_fp, data: alu_data};
        for (int i = 0; i < NSRC; i++) begin
            int_req[i] = full_q[i] & ~ent_q[i].fp;
            fp_req[i]  = full_q[i] &  ent_q[i].fp;
        end
    end

    rr_arb3 u_int_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (int_req),
        .gnt       (int_gnt),
        .gnt_valid (int_gv),
        .gnt_idx   (int_idx)
    );

    rr_arb3 u_fp_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (fp_req),
        .gnt       (fp_gnt),
        .gnt_valid (fp_gv),
        .gnt_idx   (fp_idx)
    );

    // A granted buffer drains at this edge, so it can take a new entry at the same edge.
    always_comb begin
        gnt       = int_gnt | fp_gnt;
        src_ready = ~full_q | gnt;
        accept    = src_valid & src_ready;
        for (int i = 0; i < NSRC; i++) begin
            full_d[i] = accept[i] | (full_q[i] & ~gnt[i]);
            ent_d[i]  = accept[i] ? src_ent[i] : ent_q[i];
        end
    end

    assign ld_ready  = src_ready[SRC_LD];
    assign fpu_ready = src_ready[SRC_FPU];
    assign alu_ready = src_ready[SRC_ALU];

    // x0 entries are consumed but never produce an int write strobe.
    always_comb begin
        int_ent  = ent_q[int_idx];
        fp_ent   = ent_q[fp_idx];
        we_d     = int_gv && (int_ent.rd != '0);
        waddr_d  = int_gv ? int_ent.rd   : waddr_q;
        wdata_d  = int_gv ? int_ent.data : wdata_q;
        wef_d    = fp_gv;
        waddrf_d = fp_gv ? fp_ent.rd   : waddrf_q;
        wdataf_d = fp_gv ? fp_ent.data : wdataf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            for (int i = 0; i < NSRC; i++) ent_q[i] <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wef_q    <= 1'b0;
            waddrf_q <= '0;
            wdataf_q <= '0;
        end else begin
            full_q   <= full_d;
            for (int i = 0; i < NSRC; i++) ent_q[i] <= ent_d[i];
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wef_q    <= wef_d;
            waddrf_q <= waddrf_d;
            wdataf_q <= wdataf_d;
        end
    end

    assign we             = we_q;
    assign write_address  = waddr_q;
    assign data_in        = wdata_q;
    assign wef            = wef_q;
    assign write_addressf = waddrf_q;
    assign data_inf       = wdataf_q;
    assign wb_busy        = (|full_q) | we_q | wef_q;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: expected writes are queued at stimulus
// time and a negedge monitor pops them whenever we/wef is asserted.
module tb_wb_arbiter_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int EW   = AW + XLEN;

  logic            clk, rst_n;
  logic            ld_valid, ld_ready, ld_fp;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            fpu_valid, fpu_ready, fpu_fp;
  logic [AW-1:0]   fpu_rd;
  logic [XLEN-1:0] fpu_data;
  logic            alu_valid, alu_ready, alu_fp;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            we, wef, wb_busy;
  logic [AW-1:0]   write_address, write_addressf;
  logic [XLEN-1:0] data_in, data_inf;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_int_q[$];
  logic [EW-1:0] exp_fp_q[$];

  wb_arbiter_stage #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_fp(ld_fp), .ld_data(ld_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_fp(fpu_fp), .fpu_data(fpu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_fp(alu_fp), .alu_data(alu_data),
    .we(we), .write_address(write_address), .data_in(data_in),
    .wef(wef), .write_addressf(write_addressf), .data_inf(data_inf),
    .wb_busy(wb_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        tests++;
        if (exp_int_q.size() == 0) begin
          fails++;
          $display("FAIL int_write_unexpected: got addr=%0d data=0x%0h expected none at %0t",
                   write_address, data_in, $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_int_q.pop_front();
          if ({write_address, data_in} !== e) begin
            fails++;
            $display("FAIL int_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                     write_address, data_in, e[EW-1:XLEN], e[XLEN-1:0], $time);
          end
        end
      end
      if (wef) begin
        tests++;
        if (exp_fp_q.size() == 0) begin
          fails++;
          $display("FAIL fp_write_unexpected: got addr=%0d data=0x%0h expected none at %0t",
                   write_addressf, data_inf, $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_fp_q.pop_front();
          if ({write_addressf, data_inf} !== e) begin
            fails++;
            $display("FAIL fp_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                     write_addressf, data_inf, e[EW-1:XLEN], e[XLEN-1:0], $time);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [AW-1:0] rd,
                       input logic fp, input logic [XLEN-1:0] d);
    case (s)
      0: begin ld_valid  = v; ld_rd  = rd; ld_fp  = fp; ld_data  = d; end
      1: begin fpu_valid = v; fpu_rd = rd; fpu_fp = fp; fpu_data = d; end
      default: begin alu_valid = v; alu_rd = rd; alu_fp = fp; alu_data = d; end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic push_int(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_int_q.push_back({a, d});
  endtask

  task automatic push_fp(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_fp_q.push_back({a, d});
  endtask

  initial begin
    logic [2:0] acc;
    logic [2:0] rdy;
    logic [2:0] exp_rdy [4];
    int idx [3];
    int cyc;

    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_we", we, 0);
    check("rst_wef", wef, 0);
    check("rst_addr", write_address, 0);
    check("rst_addrf", write_addressf, 0);
    check("rst_data", data_in, 0);
    check("rst_dataf", data_inf, 0);
    check("rst_busy", wb_busy, 0);
    check("rst_ready", {alu_ready, fpu_ready, ld_ready}, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single ALU write, two-cycle latency
    drive(2, 1'b1, 5'd5, 1'b0, 32'hDEADBEEF);
    push_int(5'd5, 32'hDEADBEEF);
    #1;
    check("t1_alu_ready", alu_ready, 1);
    step();
    idle_all();
    #1;
    check("t1_we_cycle1", we, 0);
    step();
    check("t1_we_cycle2", we, 1);
    check("t1_addr", write_address, 5);
    check("t1_data", data_in, 32'hDEADBEEF);
    check("t1_wef", wef, 0);
    step(); step();

    // x0 consumed silently, f0 written
    drive(2, 1'b1, 5'd0, 1'b0, 32'h55);
    #1;
    check("t2_alu_ready_x0", alu_ready, 1);
    step();
    idle_all();
    #1;
    check("t2_busy_full", wb_busy, 1);
    step();
    check("t2_we_x0", we, 0);
    check("t2_busy_drained", wb_busy, 0);
    drive(1, 1'b1, 5'd0, 1'b1, 32'h3F800000);
    push_fp(5'd0, 32'h3F800000);
    step();
    idle_all();
    step();
    check("t2_wef_f0", wef, 1);
    check("t2_addrf_f0", write_addressf, 0);
    step(); step();

    // load and ALU collide on the int file
    drive(0, 1'b1, 5'd3, 1'b0, 32'h11);
    drive(2, 1'b1, 5'd4, 1'b0, 32'h22);
    push_int(5'd3, 32'h11);
    push_int(5'd4, 32'h22);
    #1;
    check("t3_both_ready", {alu_ready, ld_ready}, 2'b11);
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(2, 1'b1, 5'd6, 1'b0, 32'h33);
    #1;
    check("t3_alu_blocked", alu_ready, 0);
    step();
    check("t3_we_n", we, 1);
    check("t3_addr_n", write_address, 3);
    check("t3_alu_ready_granted", alu_ready, 1);
    push_int(5'd6, 32'h33);
    step();
    idle_all();
    check("t3_addr_n1", write_address, 4);
    step();
    check("t3_addr_n2", write_address, 6);
    step(); step();

    // int and fp writes in the same cycle
    drive(0, 1'b1, 5'd1, 1'b1, 32'h40000000);
    drive(2, 1'b1, 5'd2, 1'b0, 32'h7);
    push_fp(5'd1, 32'h40000000);
    push_int(5'd2, 32'h7);
    step();
    idle_all();
    step();
    check("t4_we_wef", {we, wef}, 2'b11);
    check("t4_addr", write_address, 2);
    check("t4_addrf", write_addressf, 1);
    step(); step();

    // three sources, two items each, contending for the int file
    exp_rdy[0] = 3'b111;
    exp_rdy[1] = 3'b001;
    exp_rdy[2] = 3'b010;
    exp_rdy[3] = 3'b100;
    push_int(5'd10, 32'hA0);
    push_int(5'd12, 32'hB0);
    push_int(5'd14, 32'hC0);
    push_int(5'd11, 32'hA1);
    push_int(5'd13, 32'hB1);
    push_int(5'd15, 32'hC1);
    for (int s = 0; s < 3; s++) idx[s] = 0;
    cyc = 0;
    while ((idx[0] < 2 || idx[1] < 2 || idx[2] < 2) && cyc < 20) begin
      drive(0, idx[0] < 2, 5'(10 + idx[0]), 1'b0, 32'(32'hA0 + idx[0]));
      drive(1, idx[1] < 2, 5'(12 + idx[1]), 1'b0, 32'(32'hB0 + idx[1]));
      drive(2, idx[2] < 2, 5'(14 + idx[2]), 1'b0, 32'(32'hC0 + idx[2]));
      #1;
      rdy = {alu_ready, fpu_ready, ld_ready};
      acc = rdy & {alu_valid, fpu_valid, ld_valid};
      if (cyc < 4) check($sformatf("t5_ready_c%0d", cyc), rdy, exp_rdy[cyc]);
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) if (acc[s]) idx[s]++;
      cyc++;
    end
    idle_all();
    check("t5_accept_done", cyc < 20, 1);
    repeat (8) step();

    // reset with all buffers full and a write in flight
    drive(0, 1'b1, 5'd20, 1'b0, 32'h200);
    drive(1, 1'b1, 5'd21, 1'b0, 32'h210);
    drive(2, 1'b1, 5'd22, 1'b0, 32'h220);
    push_int(5'd20, 32'h200);
    step();
    drive(0, 1'b1, 5'd23, 1'b0, 32'h230);
    drive(1, 1'b0, '0, 1'b0, '0);
    drive(2, 1'b0, '0, 1'b0, '0);
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    check("t6_we_before_rst", we, 1);
    check("t6_busy_before_rst", wb_busy, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we_async", we, 0);
    check("t6_wef_async", wef, 0);
    check("t6_busy_async", wb_busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    drive(0, 1'b1, 5'd25, 1'b0, 32'hA5);
    drive(1, 1'b1, 5'd26, 1'b0, 32'hB6);
    push_int(5'd25, 32'hA5);
    push_int(5'd26, 32'hB6);
    step();
    idle_all();
    step();
    check("t6_first_grant_load", write_address, 25);
    repeat (6) step();

    check("int_queue_empty", exp_int_q.size(), 0);
    check("fp_queue_empty", exp_fp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
